mem_copy_dma: RTL
=================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter DEPTH, default 16384: number of 32-bit words in the attached RAM; valid word addresses are 0..DEPTH-1.
REQ-002 Parameter LEN_W, default 16: width of the transfer-length field.
REQ-003 Port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: request a transfer; sampled only in IDLE.
REQ-006 Port abort, input, 1: terminate the current transfer.
REQ-007 Port src_addr, input, 32: first source word address; captured on an accepted start.
REQ-008 Port dst_addr, input, 32: first destination word address; captured on an accepted start.
REQ-009 Port len, input, LEN_W: number of words to copy; captured on an accepted start.
REQ-010 Port busy, output, 1: high while a transfer is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when a transfer completes normally.
REQ-012 Port address, output, 32: RAM word address.
REQ-013 Port memrd, output, 1: RAM read enable; the RAM read path is combinational.
REQ-014 Port memwr, output, 1: RAM write enable; the RAM write occurs on the clk edge.
REQ-015 Port ram_in, output, 32: RAM write data.
REQ-016 Port ram_out, input, 32: RAM read data.

Function
REQ-017 The block SHALL implement the states IDLE, RD, WR and FIN.
REQ-018 In IDLE, start=1 with len>0 SHALL capture src_addr, dst_addr and len, and the block SHALL enter RD at the next edge.
REQ-019 In IDLE, start=1 with len=0 SHALL go to FIN without asserting memrd or memwr.
REQ-020 In RD, the block SHALL drive address=current source address and memrd=1, and SHALL latch ram_out into the data register at the closing edge; it then enters WR.
REQ-021 In WR, the block SHALL drive address=current destination address, memwr=1 and ram_in=data register; at the closing edge it increments both addresses and decrements the remaining count.
REQ-022 After the WR cycle in which the remaining count reaches 0, the block SHALL enter FIN; otherwise it returns to RD.
REQ-023 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-024 A transfer of N words SHALL take 2N busy cycles plus one FIN cycle; busy is high in RD and WR only.
REQ-025 memrd and memwr SHALL never be high in the same cycle.
REQ-026 memrd and memwr SHALL both be 0 in IDLE and FIN.
REQ-027 Address increments SHALL wrap from DEPTH-1 to 0.
REQ-028 Start addresses of DEPTH or above SHALL be reduced modulo DEPTH at capture.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 Overlapping source and destination regions SHALL follow strict ascending word-by-word semantics; no overlap correction is performed.
REQ-031 abort=1 in RD or WR SHALL suppress that cycle's memwr, return the block to IDLE at the next edge, and produce no done pulse.
REQ-032 abort=1 together with start=1 in IDLE SHALL give abort priority: start is ignored.
REQ-033 abort in FIN SHALL have no effect; the done pulse is still emitted.

Reset
REQ-034 rst=1 SHALL force state IDLE and set busy=0, done=0, memrd=0, memwr=0, address=0, ram_in=0, all internal counters and registers to 0, and the checksum (if present) to 0.
REQ-035 A reset during RD or WR SHALL abandon the transfer with no further RAM write.
REQ-036 rst SHALL take priority over start and abort.

Configuration
REQ-037 With macro MEM_COPY_DMA_CHECKSUM_EN defined, the block SHALL add output checksum (32 bits), cleared on an accepted start and accumulating, modulo 2^32, each word latched in RD.
REQ-038 With MEM_COPY_DMA_CHECKSUM_EN defined, checksum SHALL hold its value from FIN until the next accepted start.
REQ-039 Without MEM_COPY_DMA_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-040 The state enum (IDLE/RD/WR/FIN) and the DEPTH default constant SHALL reside in a shared package, mem_dma_pkg.
REQ-041 The address-wrap incrementer SHALL be a sub-module, addr_wrap_inc, instantiated twice (source and destination).
REQ-042 The verification bench SHALL pair the block with the project RAM model.

Verification
REQ-043 Preload RAM[100..103]=A,B,C,D; start with src=100, dst=200, len=4 -> RAM[200..203]=A,B,C,D; busy high for 8 cycles; done pulse in cycle 9.
REQ-044 start with len=0 -> no memrd or memwr; done high exactly one cycle after the start cycle.
REQ-045 src=16383, dst=10, len=2 -> reads addresses 16383 then 0; writes addresses 10 then 11.
REQ-046 abort asserted during the 2nd WR of a len=4 transfer -> only dst+0 written; no done pulse; busy low next cycle.
REQ-047 rst asserted during RD -> all outputs 0 next cycle; destination RAM unchanged thereafter.
REQ-048 With MEM_COPY_DMA_CHECKSUM_EN, copy words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the word-copy DMA: FSM state encoding and default RAM depth.
package mem_dma_pkg;

  localparam int DEPTH_DEFAULT = 16384;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_e;

  // Address register width for a RAM of the given depth (at least one bit).
  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/addr_wrap_inc.sv
// Word-address incrementer that wraps from DEPTH-1 back to 0.
module addr_wrap_inc #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] addr_next
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_comb begin
    addr_next = addr + AW'(1);
    if (addr == LAST) addr_next = '0;
  end

endmodule

// File: rtl/mem_copy_dma.sv
// Word-by-word RAM-to-RAM copy engine (RD/WR alternation, one FIN cycle with done).
// Optional running checksum of copied words: define MEM_COPY_DMA_CHECKSUM_EN.
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      address,
  output logic             memrd,
  output logic             memwr,
  output logic [31:0]      ram_in,
  input  logic [31:0]      ram_out,
`ifdef MEM_COPY_DMA_CHECKSUM_EN
  output logic [31:0]      checksum,
`endif
  output dma_state_e       state_dbg
);

  localparam int          AW      = addr_bits(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  // Control handshake: start is a level sampled only in IDLE (abort wins);
  // busy is high in RD/WR, done pulses for the single FIN cycle.
  dma_state_e       state_q, state_d;
  logic [AW-1:0]    src_q, dst_q, src_nx, dst_nx, src_cap, dst_cap;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             accept;

  assign state_dbg = state_q;
  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign src_cap   = AW'(src_addr % DEPTH_U);
  assign dst_cap   = AW'(dst_addr % DEPTH_U);

  addr_wrap_inc #(.DEPTH(DEPTH), .AW(AW)) u_src_inc (
    .addr      (src_q),
    .addr_next (src_nx)
  );

  addr_wrap_inc #(.DEPTH(DEPTH), .AW(AW)) u_dst_inc (
    .addr      (dst_q),
    .addr_next (dst_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (len == '0) ? ST_FIN : ST_RD;
      ST_RD:   state_d = abort ? ST_IDLE : ST_WR;
      ST_WR: begin
        if (abort)                    state_d = ST_IDLE;
        else if (cnt_q == LEN_W'(1))  state_d = ST_FIN;
        else                          state_d = ST_RD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && len != '0) begin
            src_q <= src_cap;
            dst_q <= dst_cap;
            cnt_q <= len;
          end
        end
        ST_RD: data_q <= ram_out;
        ST_WR: begin
          // Aborted write cycles leave the pointers where they were.
          if (!abort) begin
            src_q <= src_nx;
            dst_q <= dst_nx;
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_COPY_DMA_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state_q == ST_RD && !abort) begin
      checksum <= checksum + ram_out;
    end
  end
`endif

  // Outputs are decoded from state and forced low while rst is high so a
  // reset landing in WR cannot leak a final write.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    memrd   = 1'b0;
    memwr   = 1'b0;
    address = '0;
    ram_in  = '0;
    if (!rst) begin
      case (state_q)
        ST_RD: begin
          busy    = 1'b1;
          memrd   = 1'b1;
          address = 32'(src_q);
        end
        ST_WR: begin
          busy    = 1'b1;
          memwr   = !abort;
          address = 32'(dst_q);
          ram_in  = data_q;
        end
        ST_FIN:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
